// File: rtl/ps2_command_out_pkg.sv
// Shared constants and helpers for the PS/2 host-to-device command transmitter.
// Cycle defaults assume a 50 MHz system clock.
package ps2_command_out_pkg;

    localparam int CYCLES_101US_DEF = 5050;
    localparam int CYCLES_15MS_DEF  = 750000;
    localparam int CYCLES_2MS_DEF   = 100000;

    localparam int FRAME_W = 10;

    // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_command_out.sv
// PS/2 host-to-device transmitter: request-to-send, 8 data bits LSB first, odd parity,
// released stop bit, then waits for the device acknowledge or a timeout.
module ps2_command_out
    import ps2_command_out_pkg::*;
#(
    parameter int CYCLES_101US = CYCLES_101US_DEF,
    parameter int CYCLES_15MS  = CYCLES_15MS_DEF,
    parameter int CYCLES_2MS   = CYCLES_2MS_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] the_command,
    input  logic       send_command,
    input  logic       ps2_clk_posedge,
    input  logic       ps2_clk_negedge,
    input  logic       ps2_data,
    output logic       ps2_clk_drive_low,
    output logic       ps2_data_drive,
    output logic       ps2_data_out,
    output logic       command_was_sent,
    output logic       error_communication_timed_out,
    output logic [3:0] fsm_state_o
);

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_INHIBIT   = 4'd1;
    localparam logic [3:0] ST_WAIT_CLK  = 4'd2;
    localparam logic [3:0] ST_TX_DATA   = 4'd3;
    localparam logic [3:0] ST_TX_PARITY = 4'd4;
    localparam logic [3:0] ST_TX_STOP   = 4'd5;
    localparam logic [3:0] ST_RX_ACK    = 4'd6;
    localparam logic [3:0] ST_SENT      = 4'd7;
    localparam logic [3:0] ST_ERROR     = 4'd8;

    localparam int TW = $clog2(CYCLES_15MS);
    localparam logic [TW-1:0] TC_101US = TW'(CYCLES_101US - 1);
    localparam logic [TW-1:0] TC_15MS  = TW'(CYCLES_15MS - 1);
    localparam logic [TW-1:0] TC_2MS   = TW'(CYCLES_2MS - 1);

    logic [3:0]         state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]      timer_inc;
    logic               ack_timeout;

    // The timer saturates, so a terminal count that loses to an edge still fires later.
    assign timer_inc   = (timer_q == {TW{1'b1}}) ? timer_q : timer_q + 1'b1;
    assign ack_timeout = (timer_q >= TC_2MS);

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_inc;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (send_command) begin
                    state_d = ST_INHIBIT;
                    shift_d = {1'b1, odd_parity(the_command), the_command};
                end
            end
            ST_INHIBIT: begin
                if (timer_q == TC_101US) begin
                    state_d = ST_WAIT_CLK;
                    timer_d = '0;
                end
            end
            ST_WAIT_CLK: begin
                if (ps2_clk_negedge) begin
                    state_d   = ST_TX_DATA;
                    bit_cnt_d = 3'd0;
                    timer_d   = '0;
                end else if (timer_q >= TC_15MS) begin
                    state_d = ST_ERROR;
                end
            end
            ST_TX_DATA: begin
                if (ps2_clk_negedge) begin
                    shift_d = {1'b1, shift_q[FRAME_W-1:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_TX_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else if (ack_timeout) begin
                    state_d = ST_ERROR;
                end
            end
            ST_TX_PARITY: begin
                if (ps2_clk_negedge) begin
                    shift_d = {1'b1, shift_q[FRAME_W-1:1]};
                    state_d = ST_TX_STOP;
                end else if (ack_timeout) begin
                    state_d = ST_ERROR;
                end
            end
            ST_TX_STOP: begin
                if (ps2_clk_negedge) begin
                    state_d = ST_RX_ACK;
                end else if (ack_timeout) begin
                    state_d = ST_ERROR;
                end
            end
            ST_RX_ACK: begin
                if (ps2_clk_posedge && !ps2_data) begin
                    state_d = ST_SENT;
                end else if (ack_timeout) begin
                    state_d = ST_ERROR;
                end
            end
            ST_SENT, ST_ERROR: begin
                if (!send_command) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // Outputs decode the state only, so reset releases both lines on the next edge.
    assign ps2_clk_drive_low = (state_q == ST_INHIBIT);
    assign ps2_data_drive    = (state_q == ST_INHIBIT) || (state_q == ST_WAIT_CLK) ||
                               (state_q == ST_TX_DATA) || (state_q == ST_TX_PARITY);
    assign ps2_data_out      = ((state_q == ST_TX_DATA) || (state_q == ST_TX_PARITY)) ?
                               shift_q[0] : 1'b0;
    assign command_was_sent              = (state_q == ST_SENT);
    assign error_communication_timed_out = (state_q == ST_ERROR);
    assign fsm_state_o                   = state_q;

endmodule

// File: tb/tb_ps2_command_out.sv
// Directed bench for ps2_command_out with shortened timeouts and a modelled PS/2 device.
module tb_ps2_command_out;

    localparam int C101 = 10;
    localparam int C15  = 300;
    localparam int C2   = 200;
    localparam int H    = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] the_command = 8'h00;
    logic       send_command = 1'b0;
    logic       ps2_clk_posedge = 1'b0;
    logic       ps2_clk_negedge = 1'b0;
    logic       ps2_data = 1'b1;
    logic       ps2_clk_drive_low;
    logic       ps2_data_drive;
    logic       ps2_data_out;
    logic       command_was_sent;
    logic       error_communication_timed_out;
    logic [3:0] fsm_state_o;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [9:0] frame;
    int         t_first;
    int         t_wait;
    logic       sent_ack;
    int         cnt_a;
    int         cnt_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ps2_command_out #(
        .CYCLES_101US(C101),
        .CYCLES_15MS (C15),
        .CYCLES_2MS  (C2)
    ) dut (
        .clk                          (clk),
        .reset                        (reset),
        .the_command                  (the_command),
        .send_command                 (send_command),
        .ps2_clk_posedge              (ps2_clk_posedge),
        .ps2_clk_negedge              (ps2_clk_negedge),
        .ps2_data                     (ps2_data),
        .ps2_clk_drive_low            (ps2_clk_drive_low),
        .ps2_data_drive               (ps2_data_drive),
        .ps2_data_out                 (ps2_data_out),
        .command_was_sent             (command_was_sent),
        .error_communication_timed_out(error_communication_timed_out),
        .fsm_state_o                  (fsm_state_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic line_val();
        return ps2_data_drive ? ps2_data_out : 1'b1;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, " clk_low"}, ps2_clk_drive_low, 0);
        check({tag, " data_drive"}, ps2_data_drive, 0);
        check({tag, " data_out"}, ps2_data_out, 0);
        check({tag, " sent"}, command_was_sent, 0);
        check({tag, " error"}, error_communication_timed_out, 0);
    endtask

    task automatic pulse_neg();
        ps2_clk_negedge = 1'b1;
        @(negedge clk);
        ps2_clk_negedge = 1'b0;
    endtask

    task automatic pulse_pos();
        ps2_clk_posedge = 1'b1;
        @(negedge clk);
        ps2_clk_posedge = 1'b0;
    endtask

    // Raise the request and measure the clock-inhibit phase; returns in WAIT_CLK.
    task automatic start_send(input logic [7:0] cmd, input string tag);
        int   inh;
        logic start_bad;
        inh = 0;
        start_bad = 1'b0;
        the_command = cmd;
        send_command = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ps2_clk_drive_low) begin
                inh++;
                if (!(ps2_data_drive && !ps2_data_out)) start_bad = 1'b1;
            end else if (inh > 0) begin
                break;
            end
        end
        the_command = ~cmd;
        check({tag, " inhibit_len"}, inh, C101);
        check({tag, " start_bit_inhibit"}, start_bad, 0);
        check({tag, " start_bit_wait"}, {ps2_data_drive, ps2_data_out}, 2'b10);
    endtask

    // Device clocks n falling edges; the line is captured just after each one.
    task automatic device_xfer(input int n, input logic do_ack, output logic [9:0] fr,
                               output int tf, output logic ack_seen);
        fr = '0;
        tf = 0;
        ack_seen = 1'b0;
        for (int i = 1; i <= n; i++) begin
            pulse_neg();
            if (i == 1) tf = cyc;
            if (i <= 10) fr[i-1] = line_val();
            repeat (H) @(negedge clk);
            if (i == 11 && do_ack) ps2_data = 1'b0;
            pulse_pos();
            ps2_data = 1'b1;
            if (i == 11) ack_seen = command_was_sent;
            repeat (H) @(negedge clk);
        end
    endtask

    task automatic wait_error(output int waited);
        waited = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            waited++;
            if (error_communication_timed_out) break;
        end
        check("error_reached", error_communication_timed_out, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        check("reset state", fsm_state_o, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 0xED, the_command scrambled after accept
        start_send(8'hED, "ed");
        device_xfer(11, 1'b1, frame, t_first, sent_ack);
        check("ed frame", frame, 10'h3ED);
        check("ed sent", sent_ack, 1);
        check("ed error", error_communication_timed_out, 0);
        cnt_a = 0;
        cnt_b = 0;
        repeat (30) begin
            @(negedge clk);
            if (ps2_clk_drive_low) cnt_a++;
            if (!command_was_sent) cnt_b++;
        end
        check("ed no_retransmit", cnt_a, 0);
        check("ed sent_held", cnt_b, 0);
        send_command = 1'b0;
        @(negedge clk);
        check("ed sent_cleared", command_was_sent, 0);
        @(negedge clk);

        start_send(8'hF4, "f4");
        device_xfer(11, 1'b1, frame, t_first, sent_ack);
        check("f4 frame", frame, 10'h2F4);
        check("f4 sent", sent_ack, 1);
        send_command = 1'b0;
        repeat (2) @(negedge clk);

        // request withdrawn mid-frame: transfer still completes, then back to idle
        start_send(8'h00, "00");
        send_command = 1'b0;
        device_xfer(11, 1'b1, frame, t_first, sent_ack);
        check("00 frame", frame, 10'h300);
        check("00 sent_pulse", sent_ack, 1);
        check_idle_outputs("00 after");
        check("00 state", fsm_state_o, 0);

        // no device clock after release
        start_send(8'h55, "noclk");
        wait_error(t_wait);
        check("noclk wait", t_wait, C15);
        check("noclk clk_low", ps2_clk_drive_low, 0);
        check("noclk data_drive", ps2_data_drive, 0);
        check("noclk sent", command_was_sent, 0);
        send_command = 1'b0;
        @(negedge clk);
        check("noclk error_cleared", error_communication_timed_out, 0);
        @(negedge clk);

        // all bits clocked but no acknowledge
        start_send(8'hA5, "noack");
        device_xfer(11, 1'b0, frame, t_first, sent_ack);
        check("noack frame", frame, 10'h3A5);
        wait_error(t_wait);
        check("noack timeout_at", cyc - t_first, C2);
        check("noack sent", command_was_sent, 0);
        send_command = 1'b0;
        repeat (2) @(negedge clk);

        // reset in the middle of the data bits
        start_send(8'h5A, "rst");
        device_xfer(5, 1'b0, frame, t_first, sent_ack);
        check("rst bit4_on_line", line_val(), 1);
        reset = 1'b1;
        send_command = 1'b0;
        @(negedge clk);
        check_idle_outputs("rst mid");
        check("rst state", fsm_state_o, 0);
        reset = 1'b0;
        @(negedge clk);
        start_send(8'h5A, "rst2");
        device_xfer(11, 1'b1, frame, t_first, sent_ack);
        check("rst2 frame", frame, 10'h35A);
        check("rst2 sent", sent_ack, 1);
        send_command = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
